// File: rtl/regfile_tagged.sv
// regfile_tagged: architectural register file with per-register rename state.
// Each register holds a value, a busy bit and the ROB tag of its latest
// producer. Issue renames a destination onto a tag. Commit writes data and
// releases busy only when the committing tag is still the owner. Two
// combinational read ports bypass a same-cycle commit.
module regfile_tagged #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int TAGW = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic [TAGW-1:0] iss_tag,
    input  logic            cmt_valid,
    input  logic [AW-1:0]   cmt_addr,
    input  logic [TAGW-1:0] cmt_tag,
    input  logic [XLEN-1:0] cmt_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [TAGW-1:0] rs1_tag,
    output logic [TAGW-1:0] rs2_tag
);

    logic [XLEN-1:0] data_q [NREG];
    logic [TAGW-1:0] tag_q  [NREG];
    logic [NREG-1:0] busy_q;

    logic            cmt_live;
    logic            iss_live;
    logic            cmt_owner;

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];
    logic [TAGW-1:0] rd_tag  [2];

    // Address 0 is hardwired, so commits and issues to it are dropped here.
    // Flush blocks issue; the commit still writes its data.
    assign cmt_live  = cmt_valid && (cmt_addr != '0);
    assign iss_live  = iss_valid && (iss_addr != '0) && !flush;
    assign cmt_owner = busy_q[cmt_addr] && (tag_q[cmt_addr] == cmt_tag);

    // State update. Statements later in the block win, so issue overrides the
    // busy release of a commit to the same register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy_q <= '0;
            end
            if (cmt_live) begin
                data_q[cmt_addr] <= cmt_data;
                if (cmt_owner) begin
                    busy_q[cmt_addr] <= 1'b0;
                end
            end
            if (iss_live) begin
                busy_q[iss_addr] <= 1'b1;
                tag_q[iss_addr]  <= iss_tag;
            end
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Read ports: stored state with a same-cycle commit bypass. Same-cycle
    // issue is deliberately not forwarded so rs==rd sees the prior mapping.
    // The bypass ignores rdy because the ROB presents cmt_* regardless.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
            if (!rst && (rd_addr[p] != '0)) begin
                rd_data[p] = data_q[rd_addr[p]];
                rd_busy[p] = busy_q[rd_addr[p]];
                rd_tag[p]  = busy_q[rd_addr[p]] ? tag_q[rd_addr[p]] : '0;
                if (cmt_valid && (cmt_addr == rd_addr[p])) begin
                    rd_data[p] = cmt_data;
                    if (busy_q[rd_addr[p]] && (tag_q[rd_addr[p]] == cmt_tag)) begin
                        rd_busy[p] = 1'b0;
                        rd_tag[p]  = '0;
                    end
                end
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_tag  = rd_tag[0];
    assign rs2_data = rd_data[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_tag  = rd_tag[1];

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file with per-register rename state (busy bit plus reorder-buffer tag) for the out-of-order core. Sits between decode/issue and the reorder buffer. Issue marks a destination register as pending on a ROB tag. ROB commit writes back data and clears the pending state only when the committing tag is still the latest owner. Two combinational read ports return either a value or the tag to wait on, with same-cycle commit bypass and a flush path for branch mispredicts.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers; power of two, ≥2
- TAGW, 4, ROB tag width
- AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes busy/tag/data state (rst still acts)
- flush  in  1  mispredict flush; clears every busy bit
- iss_valid  in  1  rename destination this cycle
- iss_addr  in  AW  destination register
- iss_tag  in  TAGW  ROB tag assigned to that destination
- cmt_valid  in  1  ROB commit this cycle
- cmt_addr  in  AW  committed destination register
- cmt_tag  in  TAGW  ROB tag of committing entry
- cmt_data  in  XLEN  committed value
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  register value (valid when busy=0)
- rs1_busy, rs2_busy  out  1  operand still pending in ROB
- rs1_tag, rs2_tag  out  TAGW  tag to wait on; 0 when busy=0

## Operation
- State: data[NREG], busy[NREG], tag[NREG]. Register 0: data always 0, never busy; writes, issues and commits to address 0 are ignored.
- Reset (rst=1 at edge): all data, busy and tag cleared to 0. While rst=1, all read outputs are 0.
- rdy=0: no state changes, including commit, issue and flush. Reads remain live.
- Commit (cmt_valid, cmt_addr≠0): data[cmt_addr]←cmt_data unconditionally. busy[cmt_addr]←0 only if busy=1 and tag[cmt_addr]==cmt_tag, so a stale commit does not clear a newer rename.
- Issue (iss_valid, iss_addr≠0, flush=0): busy[iss_addr]←1, tag[iss_addr]←iss_tag.
- Issue and commit on the same register in one cycle: data is written, issue wins busy/tag (ends busy=1, tag=iss_tag).
- Flush: all busy←0 (tags may keep stale values, but output tag is masked to 0). Issue in the same cycle is ignored. Commit in the same cycle still writes data.
- Read port n (combinational):
  - If rst or addr=0: data=0, busy=0, tag=0.
  - Commit bypass: if cmt_valid and cmt_addr==addr, data=cmt_data. If busy and tag matches cmt_tag, the port reports busy=0 and tag=0.
  - Otherwise the port reports stored data, busy, and (busy ? tag : 0).
  - Same-cycle issue is NOT visible on reads. An instruction whose rs equals its own rd sees the prior mapping.
  - Bypass applies regardless of rdy.

## Timing
- Read latency 0 cycles: combinational from addresses and cmt_* inputs.
- Commit/issue/flush take effect at the next rising edge. A read in cycle N+1 reflects cycle N's updates.
- No handshake back-pressure; the caller must not issue when the ROB is full.
- Flush and rst both dominate issue; rst dominates everything.

## Test plan
- Reset: drive rst 2 cycles, release. Then rs1_addr=5 → rs1_data=0, rs1_busy=0, rs1_tag=0.
- Issue then commit: issue x3 tag=7 in cycle 0. In cycle 1, read x3 → busy=1, tag=7. In cycle 2, commit x3 tag=7 data=0xDEADBEEF → same cycle read gives busy=0, data=0xDEADBEEF. In cycle 3, stored value is 0xDEADBEEF with busy=0.
- Stale commit: issue x4 tag=2, then issue x4 tag=5, then commit x4 tag=2 data=0x11. Read shows busy=1, tag=5, and data is updated to 0x11.
- Same-cycle issue+commit on x6: prior tag=1, commit tag=1 data=0x22, issue tag=9. Same-cycle read gives busy=0, data=0x22. Next cycle gives busy=1, tag=9.
- Flush: make x1..x31 busy, then assert flush together with issue x8 tag=3. Next cycle all busy=0 and x8 is not busy.
- x0 and rdy: commit x0 data=0x55 → read x0=0. With rdy=0, issue x2 tag=4 → next cycle x2 busy=0.
